// File: rtl/mips_pkg.sv
// Shared MIPS memory-path definitions: access FSM states, access size codes, word width.
package mips_pkg;

    localparam int unsigned PALABRA_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        LEER,
        ESCRIBIR,
        FIN,
        ERR
    } estado_t;

    typedef enum logic [1:0] {
        TAM_BYTE      = 2'd0,
        TAM_MEDIA     = 2'd1,
        TAM_PALABRA   = 2'd2,
        TAM_RESERVADO = 2'd3
    } tam_t;

endpackage

// File: rtl/alineador_datos.sv
// Big-endian lane extract/extend for loads and lane insert for sub-word stores.
// Only built when ACCESO_SUBPALABRA_EN is defined.
`ifdef ACCESO_SUBPALABRA_EN
module alineador_datos
    import mips_pkg::*;
(
    input  logic [PALABRA_W-1:0] palabra_i,
    input  logic [1:0]           off_i,
    input  tam_t                 tam_i,
    input  logic                 sign_ext_i,
    output logic [PALABRA_W-1:0] carga_o,
    input  logic [PALABRA_W-1:0] viejo_i,
    input  logic [15:0]          nuevo_i,
    output logic [PALABRA_W-1:0] fusion_o
);

    logic [7:0]  byte_sel;
    logic [15:0] media_sel;

    always_comb begin
        unique case (off_i)
            2'd0: byte_sel = palabra_i[31:24];
            2'd1: byte_sel = palabra_i[23:16];
            2'd2: byte_sel = palabra_i[15:8];
            2'd3: byte_sel = palabra_i[7:0];
        endcase
        media_sel = off_i[1] ? palabra_i[15:0] : palabra_i[31:16];
        unique case (tam_i)
            TAM_BYTE:  carga_o = {{24{sign_ext_i & byte_sel[7]}}, byte_sel};
            TAM_MEDIA: carga_o = {{16{sign_ext_i & media_sel[15]}}, media_sel};
            default:   carga_o = palabra_i;
        endcase
    end

    always_comb begin
        fusion_o = viejo_i;
        if (tam_i == TAM_BYTE) begin
            unique case (off_i)
                2'd0: fusion_o[31:24] = nuevo_i[7:0];
                2'd1: fusion_o[23:16] = nuevo_i[7:0];
                2'd2: fusion_o[15:8]  = nuevo_i[7:0];
                2'd3: fusion_o[7:0]   = nuevo_i[7:0];
            endcase
        end else if (tam_i == TAM_MEDIA) begin
            if (off_i[1]) fusion_o[15:0]  = nuevo_i;
            else          fusion_o[31:16] = nuevo_i;
        end
    end

endmodule
`endif

// File: rtl/unidad_acceso_memoria.sv
// Multi-cycle load/store initiator between the core and Memoria_Datos.
// ACCESO_SUBPALABRA_EN enables byte/halfword accesses (RMW stores); otherwise word-only.
module unidad_acceso_memoria
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = PALABRA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              is_store,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] store_data,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [DATA_W-1:0] load_data,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    estado_t           estado_q;
    logic              busy_q, done_q, error_q;
    logic [ADDR_W-3:0] pal_q;
    logic [DATA_W-1:0] dato_q, load_data_q, dato_carga;
    logic              desalineado, es_palabra;

`ifdef ACCESO_SUBPALABRA_EN
    tam_t              tam_q;
    logic [1:0]        off_q;
    logic              sext_q, is_store_q;
    logic [DATA_W-1:0] buf_q, fusion;

    alineador_datos u_alineador (
        .palabra_i  (mem_read_data),
        .off_i      (off_q),
        .tam_i      (tam_q),
        .sign_ext_i (sext_q),
        .carga_o    (dato_carga),
        .viejo_i    (buf_q),
        .nuevo_i    (dato_q[15:0]),
        .fusion_o   (fusion)
    );

    assign es_palabra = (tam_t'(size) == TAM_PALABRA);

    always_comb begin
        unique case (tam_t'(size))
            TAM_BYTE:    desalineado = 1'b0;
            TAM_MEDIA:   desalineado = addr[0];
            TAM_PALABRA: desalineado = |addr[1:0];
            default:     desalineado = 1'b1;
        endcase
    end

    assign mem_write_data = (tam_q == TAM_PALABRA) ? dato_q : fusion;
`else
    logic sign_ext_unused;

    assign sign_ext_unused = sign_ext;
    assign es_palabra      = (size == TAM_PALABRA);
    assign desalineado     = !es_palabra || (|addr[1:0]);
    assign dato_carga      = mem_read_data;
    assign mem_write_data  = dato_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q    <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            pal_q       <= '0;
            dato_q      <= '0;
            load_data_q <= '0;
`ifdef ACCESO_SUBPALABRA_EN
            tam_q       <= TAM_BYTE;
            off_q       <= '0;
            sext_q      <= 1'b0;
            is_store_q  <= 1'b0;
            buf_q       <= '0;
`endif
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            unique case (estado_q)
                IDLE: begin
                    busy_q <= req;
                    if (req) begin
                        pal_q  <= addr[ADDR_W-1:2];
                        dato_q <= store_data;
`ifdef ACCESO_SUBPALABRA_EN
                        tam_q      <= tam_t'(size);
                        off_q      <= addr[1:0];
                        sext_q     <= sign_ext;
                        is_store_q <= is_store;
`endif
                        if (desalineado) begin
                            estado_q <= ERR;
                            done_q   <= 1'b1;
                            error_q  <= 1'b1;
                        end else if (is_store && es_palabra) begin
                            estado_q <= ESCRIBIR;
                        end else begin
                            estado_q <= LEER;
                        end
                    end
                end
                // A sub-word store reuses LEER to capture the old word for the merge.
                LEER: begin
`ifdef ACCESO_SUBPALABRA_EN
                    if (is_store_q) begin
                        buf_q    <= mem_read_data;
                        estado_q <= ESCRIBIR;
                    end else
`endif
                    begin
                        load_data_q <= dato_carga;
                        estado_q    <= FIN;
                        done_q      <= 1'b1;
                    end
                end
                ESCRIBIR: begin
                    estado_q <= FIN;
                    done_q   <= 1'b1;
                end
                FIN, ERR: begin
                    estado_q <= IDLE;
                    busy_q   <= 1'b0;
                end
                default: begin
                    estado_q <= IDLE;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    // Strobes are gated by reset combinationally so an aborted write never commits.
    assign mem_read    = (estado_q == LEER) && !reset;
    assign mem_write   = (estado_q == ESCRIBIR) && !reset;
    assign mem_address = {pal_q, 2'b00};
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;
    assign load_data   = load_data_q;

endmodule

// File: tb/tb_unidad_acceso_memoria.sv
// Directed bench for unidad_acceso_memoria with a per-cycle expected-behaviour model;
// honours ACCESO_SUBPALABRA_EN for the expected results.
module tb_unidad_acceso_memoria;

`ifdef ACCESO_SUBPALABRA_EN
    localparam bit SUB = 1'b1;
`else
    localparam bit SUB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        is_store = 1'b0;
    logic [1:0]  size = 2'd2;
    logic        sign_ext = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] store_data = '0;
    logic        busy, done, error, mem_read, mem_write;
    logic [31:0] load_data, mem_address, mem_write_data, mem_read_data;

    unidad_acceso_memoria #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
        .is_store       (is_store),
        .size           (size),
        .sign_ext       (sign_ext),
        .addr           (addr),
        .store_data     (store_data),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .load_data      (load_data),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    always #5 clk = ~clk;

    // Data memory environment: combinational read, write at clock edge, ignores read+write.
    logic [31:0] mem [64] = '{default: 32'h0};
    logic        pre_en = 1'b0;
    logic [5:0]  pre_idx = '0;
    logic [31:0] pre_val = '0;

    always @(posedge clk) begin
        if (pre_en) mem[pre_idx] <= pre_val;
        else if (mem_write && !mem_read) mem[mem_address[7:2]] <= mem_write_data;
    end
    assign mem_read_data = mem[mem_address[7:2]];

    // Model state
    typedef struct {
        logic        busy, done, err, rd, wr;
        logic [31:0] addr, wdata, ld;
    } ent_t;

    ent_t        exp_q[$];
    logic [31:0] mdl_mem [64] = '{default: 32'h0};
    logic [31:0] ld_model = '0;
    bit          chk_en = 1'b0;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic ent_t ent(bit b, bit dn, bit e, bit r, bit w,
                                 logic [31:0] ad, logic [31:0] wd, logic [31:0] l);
        ent_t x;
        x.busy = b; x.done = dn; x.err = e; x.rd = r; x.wr = w;
        x.addr = ad; x.wdata = wd; x.ld = l;
        return x;
    endfunction

    function automatic bit mal_alineado(logic [1:0] sz, logic [31:0] a);
        if (SUB)
            return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
        else
            return (sz != 2'd2) || (a[1:0] != 2'd0);
    endfunction

    function automatic logic [31:0] extraer(logic [31:0] w, logic [1:0] sz, bit sx, logic [1:0] off);
        int unsigned sh;
        logic [31:0] v;
        if (sz == 2'd0) begin
            sh = 24 - 8 * int'(off);
            v  = (w >> sh) & 32'hFF;
            if (sx && v[7]) v = v | 32'hFFFFFF00;
        end else if (sz == 2'd1) begin
            sh = 16 - 8 * int'(off);
            v  = (w >> sh) & 32'hFFFF;
            if (sx && v[15]) v = v | 32'hFFFF0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] fusionar(logic [31:0] w, logic [31:0] d, logic [1:0] sz, logic [1:0] off);
        int unsigned sh;
        logic [31:0] m;
        if (sz == 2'd0) begin
            sh = 24 - 8 * int'(off);
            m  = 32'hFF << sh;
        end else begin
            sh = 16 - 8 * int'(off);
            m  = 32'hFFFF << sh;
        end
        return (w & ~m) | ((d << sh) & m);
    endfunction

    // Compare process: one expected entry per cycle, idle expectation when no access pending.
    always @(negedge clk) begin
        if (chk_en) begin
            ent_t e;
            if (exp_q.size() != 0) e = exp_q.pop_front();
            else e = ent(0, 0, 0, 0, 0, 32'h0, 32'h0, ld_model);
            chk("busy",      32'(busy),      32'(e.busy));
            chk("done",      32'(done),      32'(e.done));
            chk("error",     32'(error),     32'(e.err));
            chk("mem_read",  32'(mem_read),  32'(e.rd));
            chk("mem_write", 32'(mem_write), 32'(e.wr));
            chk("load_data", load_data,      e.ld);
            if (e.rd || e.wr) chk("mem_address", mem_address, e.addr);
            if (e.wr) chk("mem_write_data", mem_write_data, e.wdata);
        end
    end

    task automatic wait_q(input int n);
        for (int i = 0; i < 40 && exp_q.size() > n; i++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() > n) begin
            vectors++;
            miscompares++;
            $display("FAIL espera: %0d entries pending, expected at most %0d", exp_q.size(), n);
            exp_q.delete();
        end
    endtask

    task automatic preset(input logic [5:0] idx, input logic [31:0] val);
        @(posedge clk);
        #1;
        pre_en = 1'b1; pre_idx = idx; pre_val = val;
        mdl_mem[idx] = val;
        @(posedge clk);
        #1;
        pre_en = 1'b0;
    endtask

    task automatic acceso(input bit st, input logic [1:0] sz, input bit sx,
                          input logic [31:0] a, input logic [31:0] d, input int reps);
        int          por;
        logic [31:0] w, nv, wa;
        logic [5:0]  idx;
        @(posedge clk);
        #1;
        idx = a[7:2];
        wa  = a & 32'hFFFFFFFC;
        for (int r = 0; r < reps; r++) begin
            w = mdl_mem[idx];
            exp_q.push_back(ent(0, 0, 0, 0, 0, 32'h0, 32'h0, ld_model));
            if (mal_alineado(sz, a)) begin
                exp_q.push_back(ent(1, 1, 1, 0, 0, 32'h0, 32'h0, ld_model));
            end else if (!st) begin
                nv = extraer(w, sz, sx, a[1:0]);
                exp_q.push_back(ent(1, 0, 0, 1, 0, wa, 32'h0, ld_model));
                exp_q.push_back(ent(1, 1, 0, 0, 0, 32'h0, 32'h0, nv));
                ld_model = nv;
            end else if (sz == 2'd2) begin
                exp_q.push_back(ent(1, 0, 0, 0, 1, wa, d, ld_model));
                exp_q.push_back(ent(1, 1, 0, 0, 0, 32'h0, 32'h0, ld_model));
                mdl_mem[idx] = d;
            end else begin
                nv = fusionar(w, d, sz, a[1:0]);
                exp_q.push_back(ent(1, 0, 0, 1, 0, wa, 32'h0, ld_model));
                exp_q.push_back(ent(1, 0, 0, 0, 1, wa, nv, ld_model));
                exp_q.push_back(ent(1, 1, 0, 0, 0, 32'h0, 32'h0, ld_model));
                mdl_mem[idx] = nv;
            end
        end
        por = exp_q.size() / reps;
        req = 1'b1; is_store = st; size = sz; sign_ext = sx; addr = a; store_data = d;
        wait_q(por - 1);
        @(posedge clk);
        #1;
        req = 1'b0;
        wait_q(0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk_en = 1'b1;
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_load_data", load_data, 32'h0);

        // Word store then word load
        acceso(1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 1);
        acceso(0, 2'd2, 0, 32'h10, 32'h0, 1);
        chk("lit_carga_palabra", load_data, 32'hDEADBEEF);

        // Byte RMW
        preset(6'd8, 32'h11223344);
        acceso(1, 2'd0, 0, 32'h22, 32'hFFFFFFAA, 1);
        chk("lit_rmw_byte", mem[8], SUB ? 32'h1122AA44 : 32'h11223344);

        // Lane extraction and extension
        preset(6'd8, 32'h80FF7F01);
        acceso(0, 2'd0, 1, 32'h21, 32'h0, 1);
        chk("lit_sb_21", load_data, SUB ? 32'hFFFFFFFF : 32'hDEADBEEF);
        acceso(0, 2'd1, 0, 32'h20, 32'h0, 1);
        chk("lit_uh_20", load_data, SUB ? 32'h000080FF : 32'hDEADBEEF);
        acceso(0, 2'd0, 1, 32'h22, 32'h0, 1);
        chk("lit_sb_22", load_data, SUB ? 32'h0000007F : 32'hDEADBEEF);
        acceso(0, 2'd1, 1, 32'h20, 32'h0, 1);
        acceso(0, 2'd1, 1, 32'h22, 32'h0, 1);
        acceso(0, 2'd0, 0, 32'h21, 32'h0, 1);
        acceso(0, 2'd0, 0, 32'h23, 32'h0, 1);

        // Halfword RMW
        preset(6'd11, 32'hCAFEF00D);
        acceso(1, 2'd1, 0, 32'h2E, 32'h55551234, 1);
        chk("lit_rmw_media", mem[11], SUB ? 32'hCAFE1234 : 32'hCAFEF00D);

        // Misaligned / reserved
        acceso(0, 2'd2, 0, 32'h06, 32'h0, 1);
        acceso(1, 2'd2, 0, 32'h13, 32'h77777777, 1);
        acceso(0, 2'd1, 1, 32'h21, 32'h0, 1);
        acceso(0, 2'd3, 0, 32'h20, 32'h0, 1);
        acceso(1, 2'd3, 0, 32'h24, 32'h66666666, 1);

        // Back-to-back and held request
        acceso(1, 2'd2, 0, 32'h3C, 32'h0BADF00D, 1);
        acceso(0, 2'd2, 0, 32'h3C, 32'h0, 1);
        acceso(0, 2'd2, 0, 32'h10, 32'h0, 1);
        acceso(0, 2'd2, 0, 32'h3C, 32'h0, 2);
        chk("lit_sostenido", load_data, 32'h0BADF00D);

        // Reset during ESCRIBIR of a word store
        preset(6'd12, 32'hA5A5A5A5);
        @(posedge clk);
        #1;
        exp_q.push_back(ent(0, 0, 0, 0, 0, 32'h0, 32'h0, ld_model));
        exp_q.push_back(ent(1, 0, 0, 0, 0, 32'h0, 32'h0, ld_model));
        ld_model = 32'h0;
        req = 1'b1; is_store = 1'b1; size = 2'd2; sign_ext = 1'b0;
        addr = 32'h30; store_data = 32'h12345678;
        @(posedge clk);
        #1;
        req = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        wait_q(0);
        chk("post_rst_busy", 32'(busy), 32'h0);
        chk("post_rst_done", 32'(done), 32'h0);
        chk("post_rst_error", 32'(error), 32'h0);
        chk("post_rst_load_data", load_data, 32'h0);
        chk("post_rst_strobes", {30'h0, mem_read, mem_write}, 32'h0);
        chk("lit_rst_mem30", mem[12], 32'hA5A5A5A5);

        // Access after reset still works
        acceso(0, 2'd2, 0, 32'h30, 32'h0, 1);
        chk("lit_tras_rst", load_data, 32'hA5A5A5A5);

        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b0;
        for (int i = 0; i < 64; i++) chk($sformatf("mem[%0d]", i), mem[i], mdl_mem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/unidad_acceso_memoria.md
# unidad_acceso_memoria

Multi-cycle load/store initiator between the MIPS core and `Memoria_Datos`. It accepts one load or store request from the core, drives the data memory's `read`/`write`/`address`/`write_data` port, and returns sign- or zero-extended load data with a one-cycle `done` pulse. Byte and halfword stores are done by read-modify-write, because the data memory is word-wide only. Data is big-endian: byte offset 0 maps to bits [31:24].

## Interface
- `ADDR_W`, 32, byte address width
- `DATA_W`, 32, data word width (fixed at 32)
- `clk`  in  1  clock; all state changes on rising edge
- `reset`  in  1  synchronous, active-high
- `req`  in  1  request valid; sampled only in IDLE
- `is_store`  in  1  1 = store, 0 = load
- `size`  in  2  0 = byte, 1 = halfword, 2 = word, 3 = reserved
- `sign_ext`  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- `addr`  in  32  byte address
- `store_data`  in  32  store value, right-justified for byte/halfword
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse when the access completes
- `error`  out  1  qualifies `done`: misaligned or unsupported access
- `load_data`  out  32  valid while `done`=1; holds until the next load completes
- `mem_read`  out  1  to data memory `read`
- `mem_write`  out  1  to data memory `write`
- `mem_address`  out  32  `{addr[31:2],2'b00}` of the latched request
- `mem_write_data`  out  32  word to write
- `mem_read_data`  in  32  combinational read data from memory

## Operation
- **Latch on accept.** In IDLE with `req`=1, latch `is_store`, `size`, `sign_ext`, `addr`, `store_data`.
- **Misalignment.** Halfword with `addr[0]`=1, word with `addr[1:0]`≠0, or `size`=3 goes to ERR. ERR performs no memory access.
- **States:**
  - IDLE
  - LEER: `mem_read`=1; capture the extracted lane into `load_data` register / merge buffer
  - ESCRIBIR: `mem_write`=1
  - FIN: `done`=1
  - ERR: `done`=1, `error`=1
- **Transitions:**
  - IDLE→LEER for a load or a sub-word store
  - IDLE→ESCRIBIR for a word store
  - IDLE→ERR for a misaligned or unsupported request
  - LEER→FIN for a load; LEER→ESCRIBIR for a sub-word store
  - ESCRIBIR→FIN
  - FIN→IDLE; ERR→IDLE
- **Memory strobes.** `mem_read` and `mem_write` are never high together. The memory ignores an access when both are set.
- **Read-modify-write.** In ESCRIBIR for a sub-word store, the merge word is the captured memory word with the target byte/halfword lane replaced by `store_data[7:0]` or `store_data[15:0]`.
- **Lane extraction for loads:**
  - Byte offset k takes bits [31-8k:24-8k].
  - Halfword offset 0 takes [31:16]; offset 2 takes [15:0].
  - The result is extended to 32 bits per `sign_ext`.
- **`load_data` on non-loads.** Unchanged by stores and errors.
- **`req` outside IDLE.** Ignored, including during FIN/ERR. The core must hold or re-present `req` until it sees `busy`=0.
- **Reset.**
  - `reset`=1 forces `mem_read`=`mem_write`=0 in the same cycle, gated combinationally, so an aborted ESCRIBIR never commits.
  - At the next edge: state=IDLE; `done`=`error`=`busy`=0; `load_data`=0; latched request cleared.

## Timing
- Request accepted at edge E0.
- Word load:
  - LEER in cycle after E0.
  - `done` and `load_data` valid one cycle later.
  - Latency 2 cycles from acceptance.
- Word store: ESCRIBIR in cycle 1 (memory writes at the end of it), `done` in cycle 2.
- Sub-word store: LEER cycle 1, ESCRIBIR cycle 2, `done` cycle 3.
- Error: `done`+`error` in cycle 1.
- Back-to-back throughput:
  - One access per 3 cycles (load or word store).
  - One access per 4 cycles (sub-word store).
  - The next `req` is accepted in the IDLE cycle after FIN.
- `mem_*` outputs are decoded from registered state and latched request. `mem_read_data` is sampled at the end of LEER only.

## Configuration
- `ACCESO_SUBPALABRA_EN` defined:
  - Byte and halfword loads/stores supported as above.
- Undefined:
  - Only word accesses are supported; any `size`≠2 goes to ERR.
  - The merge logic and the RMW path (LEER→ESCRIBIR) are not built.
  - `sign_ext` is ignored.

## Structure
- Shared package `mips_pkg`:
  - State encoding: IDLE, LEER, ESCRIBIR, FIN, ERR.
  - Size codes: TAM_BYTE=0, TAM_MEDIA=1, TAM_PALABRA=2.
  - Word width constant.
- Sub-module `alineador_datos`, purely combinational:
  - Load direction: lane extract + extend (word, offset, size, sign_ext → 32-bit).
  - Store direction: lane insert (old word, new data, offset, size → merged word).
  - Compiled only with `ACCESO_SUBPALABRA_EN`.

## Test plan
- Word store, then word load:
  - Store 0xDEADBEEF to 0x10.
  - Write occurs in cycle 1 with `mem_address`=0x10; `done` in cycle 2.
  - Load from 0x10 returns `load_data`=0xDEADBEEF, `error`=0, 2-cycle latency.
- Byte RMW:
  - Memory word at 0x20 = 0x11223344; store byte 0xAA to 0x22.
  - Memory becomes 0x1122AA44; `done` in cycle 3.
- Sign extension, memory word at 0x20 = 0x80FF7F01:
  - Signed byte load at 0x21 → 0xFFFFFFFF.
  - Unsigned halfword load at 0x20 → 0x000080FF.
  - Signed byte load at 0x22 → 0x0000007F.
- Misaligned: word load at 0x06 → `done`=`error`=1 in cycle 1; `mem_read`/`mem_write` stay 0 throughout.
- Reset mid-store:
  - Assert `reset` during ESCRIBIR of a store of 0x12345678 to 0x30.
  - `mem_write`=0 that cycle; the word at 0x30 keeps its prior value.
  - After reset all outputs are 0 and `busy`=0.
- `req` held high through FIN: exactly one access per request window; a second access starts only from the IDLE cycle after `done`.
